// File: rtl/temp_tracker.sv
// Multi-channel signed up/down counter bank with sign flags, sticky overflow and hysteresis alarm.
// Define TEMP_TRACKER_SAT_EN to saturate at the counter limits instead of wrapping.
module temp_tracker #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int HI_THRESH = 30,
  parameter int LO_THRESH = 25,
  localparam int CH_W     = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  input  logic [1:0]          cmd_op,
  input  logic [CH_W-1:0]     cmd_ch,
  input  logic [WIDTH-1:0]    cmd_data,
  input  logic [CH_W-1:0]     rd_ch,
  output logic [WIDTH-1:0]    rd_value,
  output logic [CHANNELS-1:0] negative,
  output logic [CHANNELS-1:0] positive,
  output logic [CHANNELS-1:0] zero,
  output logic [CHANNELS-1:0] alarm,
  output logic [CHANNELS-1:0] ovf
);

  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_INC  = 2'd2;
  localparam logic [1:0] OP_DEC  = 2'd3;

  localparam logic signed [WIDTH-1:0] HI_T  = WIDTH'(HI_THRESH);
  localparam logic signed [WIDTH-1:0] LO_T  = WIDTH'(LO_THRESH);
  localparam logic signed [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [CHANNELS-1:0][WIDTH-1:0] cnt_reg, cnt_next;
  logic [CHANNELS-1:0]            neg_reg, neg_next;
  logic [CHANNELS-1:0]            pos_reg, pos_next;
  logic [CHANNELS-1:0]            zero_reg, zero_next;
  logic [CHANNELS-1:0]            alarm_reg, alarm_next;
  logic [CHANNELS-1:0]            ovf_reg, ovf_next;
  logic [WIDTH-1:0]               rd_value_reg, rd_value_next;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic signed [WIDTH-1:0] cur;
      logic signed [WIDTH-1:0] val_next;
      logic                    ch_ovf_next;
      logic                    ch_alarm_next;
      logic                    hit;

      assign cur = cnt_reg[gi];
      // Out-of-range channel numbers never match any generated index, so they drop naturally.
      assign hit = cmd_valid && (cmd_ch == CH_W'(gi));

      always_comb begin
        val_next    = cur;
        ch_ovf_next = ovf_reg[gi];
        if (hit) begin
          case (cmd_op)
            OP_LOAD: begin
              val_next    = cmd_data;
              ch_ovf_next = 1'b0;
            end
            OP_INC: begin
              if (cur == C_MAX) begin
                ch_ovf_next = 1'b1;
`ifdef TEMP_TRACKER_SAT_EN
                val_next    = C_MAX;
`else
                val_next    = C_MIN;
`endif
              end else begin
                val_next = cur + WIDTH'(1);
              end
            end
            OP_DEC: begin
              if (cur == C_MIN) begin
                ch_ovf_next = 1'b1;
`ifdef TEMP_TRACKER_SAT_EN
                val_next    = C_MIN;
`else
                val_next    = C_MAX;
`endif
              end else begin
                val_next = cur - WIDTH'(1);
              end
            end
            default: ;
          endcase
        end
      end

      // Set wins when the thresholds coincide; between them the alarm holds.
      always_comb begin
        ch_alarm_next = alarm_reg[gi];
        if (val_next >= HI_T) begin
          ch_alarm_next = 1'b1;
        end else if (val_next <= LO_T) begin
          ch_alarm_next = 1'b0;
        end
      end

      assign cnt_next[gi]   = val_next;
      assign ovf_next[gi]   = ch_ovf_next;
      assign alarm_next[gi] = ch_alarm_next;
      assign neg_next[gi]   = val_next[WIDTH-1];
      assign zero_next[gi]  = (val_next == '0);
      assign pos_next[gi]   = !val_next[WIDTH-1] && (val_next != '0);
    end
  endgenerate

  // Read from the next-state values so a same-cycle write is visible (write-through).
  always_comb begin
    rd_value_next = '0;
    if (int'(rd_ch) < CHANNELS) begin
      rd_value_next = cnt_next[rd_ch];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_reg      <= '0;
      neg_reg      <= '0;
      pos_reg      <= '0;
      zero_reg     <= '1;
      alarm_reg    <= '0;
      ovf_reg      <= '0;
      rd_value_reg <= '0;
    end else begin
      cnt_reg      <= cnt_next;
      neg_reg      <= neg_next;
      pos_reg      <= pos_next;
      zero_reg     <= zero_next;
      alarm_reg    <= alarm_next;
      ovf_reg      <= ovf_next;
      rd_value_reg <= rd_value_next;
    end
  end

  assign rd_value = rd_value_reg;
  assign negative = neg_reg;
  assign positive = pos_reg;
  assign zero     = zero_reg;
  assign alarm    = alarm_reg;
  assign ovf      = ovf_reg;

endmodule

// File: tb/tb_temp_tracker.sv
// Directed self-checking bench for temp_tracker: a 4-channel instance plus a 3-channel
// instance sharing the same inputs, the latter used for out-of-range channel drops.
module tb_temp_tracker;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [1:0] cmd_ch = 2'd0;
  logic [7:0] cmd_data = 8'd0;
  logic [1:0] rd_ch = 2'd0;

  logic [7:0] rd_value;
  logic [3:0] negative, positive, zero, alarm, ovf;
  logic [7:0] rd_value3;
  logic [2:0] negative3, positive3, zero3, alarm3, ovf3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  temp_tracker dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ch(cmd_ch), .cmd_data(cmd_data), .rd_ch(rd_ch), .rd_value(rd_value),
    .negative(negative), .positive(positive), .zero(zero), .alarm(alarm), .ovf(ovf)
  );

  temp_tracker #(.CHANNELS(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ch(cmd_ch), .cmd_data(cmd_data), .rd_ch(rd_ch), .rd_value(rd_value3),
    .negative(negative3), .positive(positive3), .zero(zero3), .alarm(alarm3), .ovf(ovf3)
  );

  // One command per cycle; inputs change 1 time unit after the edge.
  task automatic cmd(input logic [1:0] op, input logic [1:0] ch, input logic [7:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ch    = ch;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    $display("[TB] cmd op=%0d ch=%0d data=%0d -> rd_value=%0d", op, ch, $signed(data), $signed(rd_value));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rd_ch = 2'd0;
    @(posedge clk);
    #1;
    tests++; if (zero !== 4'b1111) begin fails++; $display("FAIL reset_zero got %b exp 1111", zero); end
    tests++; if (negative !== 4'b0000) begin fails++; $display("FAIL reset_negative got %b exp 0000", negative); end
    tests++; if (positive !== 4'b0000) begin fails++; $display("FAIL reset_positive got %b exp 0000", positive); end
    tests++; if (alarm !== 4'b0000) begin fails++; $display("FAIL reset_alarm got %b exp 0000", alarm); end
    tests++; if (ovf !== 4'b0000) begin fails++; $display("FAIL reset_ovf got %b exp 0000", ovf); end
    tests++; if (rd_value !== 8'd0) begin fails++; $display("FAIL reset_rd_value got %h exp 00", rd_value); end
    tests++; if (zero3 !== 3'b111) begin fails++; $display("FAIL reset_zero3 got %b exp 111", zero3); end
  endtask

  task automatic test_count();
    rd_ch = 2'd2;
    cmd(2'd1, 2'd2, 8'hFD);
    tests++; if (negative !== 4'b0100) begin fails++; $display("FAIL load_neg got %b exp 0100", negative); end
    tests++; if (rd_value !== 8'hFD) begin fails++; $display("FAIL load_rd got %h exp fd", rd_value); end
    cmd(2'd2, 2'd2, 8'd0);
    cmd(2'd2, 2'd2, 8'd0);
    tests++; if (negative !== 4'b0100) begin fails++; $display("FAIL inc2_neg got %b exp 0100", negative); end
    cmd(2'd2, 2'd2, 8'd0);
    tests++; if (zero !== 4'b1111) begin fails++; $display("FAIL inc3_zero got %b exp 1111", zero); end
    cmd(2'd2, 2'd2, 8'd0);
    tests++; if (positive !== 4'b0100) begin fails++; $display("FAIL inc4_pos got %b exp 0100", positive); end
    tests++; if (zero !== 4'b1011) begin fails++; $display("FAIL inc4_zero got %b exp 1011", zero); end
    tests++; if (rd_value !== 8'd1) begin fails++; $display("FAIL inc4_rd got %h exp 01", rd_value); end
  endtask

  task automatic test_hysteresis();
    rd_ch = 2'd1;
    cmd(2'd1, 2'd1, 8'd29);
    tests++; if (alarm !== 4'b0000) begin fails++; $display("FAIL hys_load29 got %b exp 0000", alarm); end
    cmd(2'd2, 2'd1, 8'd0);
    tests++; if (alarm !== 4'b0010) begin fails++; $display("FAIL hys_30 got %b exp 0010", alarm); end
    for (int k = 0; k < 4; k++) begin
      cmd(2'd3, 2'd1, 8'd0);
      tests++; if (alarm !== 4'b0010) begin fails++; $display("FAIL hys_dec%0d got %b exp 0010", k, alarm); end
    end
    tests++; if (rd_value !== 8'd26) begin fails++; $display("FAIL hys_rd26 got %0d exp 26", rd_value); end
    cmd(2'd3, 2'd1, 8'd0);
    tests++; if (alarm !== 4'b0000) begin fails++; $display("FAIL hys_25 got %b exp 0000", alarm); end
    cmd(2'd1, 2'd1, 8'd40);
    tests++; if (alarm !== 4'b0010) begin fails++; $display("FAIL hys_jump_up got %b exp 0010", alarm); end
    cmd(2'd1, 2'd1, 8'd0);
    tests++; if (alarm !== 4'b0000) begin fails++; $display("FAIL hys_jump_down got %b exp 0000", alarm); end
  endtask

  task automatic test_boundary();
    logic [7:0] exp_inc;
    logic [7:0] exp_dec;
`ifdef TEMP_TRACKER_SAT_EN
    exp_inc = 8'h7F;
    exp_dec = 8'h80;
`else
    exp_inc = 8'h80;
    exp_dec = 8'h7F;
`endif
    rd_ch = 2'd0;
    cmd(2'd1, 2'd0, 8'h7F);
    tests++; if (ovf !== 4'b0000) begin fails++; $display("FAIL bnd_load_ovf got %b exp 0000", ovf); end
    cmd(2'd2, 2'd0, 8'd0);
    tests++; if (rd_value !== exp_inc) begin fails++; $display("FAIL bnd_inc_max got %h exp %h", rd_value, exp_inc); end
    tests++; if (ovf !== 4'b0001) begin fails++; $display("FAIL bnd_inc_ovf got %b exp 0001", ovf); end
    tests++; if (negative[0] !== exp_inc[7]) begin fails++; $display("FAIL bnd_inc_neg got %b exp %b", negative[0], exp_inc[7]); end
    rd_ch = 2'd3;
    cmd(2'd1, 2'd3, 8'h80);
    cmd(2'd3, 2'd3, 8'd0);
    tests++; if (rd_value !== exp_dec) begin fails++; $display("FAIL bnd_dec_min got %h exp %h", rd_value, exp_dec); end
    tests++; if (ovf !== 4'b1001) begin fails++; $display("FAIL bnd_dec_ovf got %b exp 1001", ovf); end
    cmd(2'd1, 2'd0, 8'd0);
    tests++; if (ovf !== 4'b1000) begin fails++; $display("FAIL bnd_clear_ovf got %b exp 1000", ovf); end
  endtask

  task automatic test_drop();
    do_reset();
    rd_ch = 2'd0;
    cmd(2'd1, 2'd3, 8'd9);
    tests++; if (zero3 !== 3'b111) begin fails++; $display("FAIL drop_range got %b exp 111", zero3); end
    tests++; if (positive !== 4'b1000) begin fails++; $display("FAIL drop_range_ref got %b exp 1000", positive); end
    cmd_op = 2'd1; cmd_ch = 2'd0; cmd_data = 8'd5; cmd_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (rd_value !== 8'd0) begin fails++; $display("FAIL drop_invalid got %h exp 00", rd_value); end
    cmd_op = 2'd0;
    reset_n = 1'b0;
    cmd(2'd1, 2'd0, 8'd5);
    reset_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (rd_value !== 8'd0) begin fails++; $display("FAIL drop_reset_rd got %h exp 00", rd_value); end
    tests++; if (zero !== 4'b1111) begin fails++; $display("FAIL drop_reset_zero got %b exp 1111", zero); end
  endtask

  task automatic test_back_to_back();
    rd_ch = 2'd1;
    cmd(2'd2, 2'd1, 8'd0);
    cmd(2'd2, 2'd1, 8'd0);
    cmd(2'd3, 2'd1, 8'd0);
    tests++; if (rd_value !== 8'd1) begin fails++; $display("FAIL b2b_net got %h exp 01", rd_value); end
    cmd(2'd1, 2'd1, 8'd7);
    tests++; if (rd_value !== 8'd7) begin fails++; $display("FAIL b2b_wt_read got %h exp 07", rd_value); end
    tests++; if (positive !== 4'b0010) begin fails++; $display("FAIL b2b_pos got %b exp 0010", positive); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_hysteresis();
    test_boundary();
    test_drop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/temp_tracker.md
# temp_tracker

Multi-channel signed up/down counter bank with per-channel sign flags, sticky overflow and a hysteresis threshold alarm. It is the parametrised successor to the team's single 8-bit temperature register. A single command port loads or steps one channel per cycle. A registered read port returns any channel's value. It sits between the sensor-event decoder and the display/alarm logic.

## Interface
- WIDTH, 8: counter width in bits, signed two's complement, minimum 2.
- CHANNELS, 4: number of independent counters, minimum 1.
- HI_THRESH, 30: signed alarm set threshold.
- LO_THRESH, 25: signed alarm clear threshold; must be less than or equal to HI_THRESH.
- CH_W (localparam): max($clog2(CHANNELS), 1).
- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  command strobe; one command is accepted in every cycle it is high.
- cmd_op  in  2  command opcode: 0 NOP, 1 LOAD, 2 INC, 3 DEC.
- cmd_ch  in  CH_W  target channel.
- cmd_data  in  WIDTH  LOAD value, signed.
- rd_ch  in  CH_W  read channel select.
- rd_value  out  WIDTH  registered value of channel rd_ch.
- negative  out  CHANNELS  bit i is high when counter i < 0.
- positive  out  CHANNELS  bit i is high when counter i > 0.
- zero  out  CHANNELS  bit i is high when counter i == 0.
- alarm  out  CHANNELS  bit i is the hysteresis alarm for counter i.
- ovf  out  CHANNELS  bit i is the sticky overflow/underflow flag for counter i.

## Operation
- Reset (reset_n low at an edge) takes priority over everything and produces:
  - all counters 0 and rd_value 0;
  - zero all ones; negative, positive, alarm and ovf all zeros.
- A command executes only if cmd_valid is 1 and cmd_ch < CHANNELS. Otherwise it is silently dropped. NOP does nothing.
- LOAD: counter[cmd_ch] <= cmd_data, and ovf[cmd_ch] is cleared. LOAD is the only way to clear ovf other than reset.
- INC/DEC: counter[cmd_ch] moves by ±1.
  - INC at max (2^(WIDTH-1)-1) or DEC at min (-2^(WIDTH-1)) sets ovf[cmd_ch]. The resulting value depends on TEMP_TRACKER_SAT_EN (see Configuration).
- Only the addressed channel changes. All other channels hold their value and flags.
- negative, positive and zero are registered and computed from each counter's next value, so they are coincident with the counter. Exactly one of the three is high per channel at all times.
- alarm[i] is registered from the next value:
  - set when next value >= HI_THRESH;
  - cleared when next value <= LO_THRESH;
  - otherwise holds.
  - A LOAD straight across both thresholds takes the new region's value in the same cycle.
- All comparisons are signed at WIDTH bits. HI_THRESH and LO_THRESH are truncated to WIDTH bits.

## Timing
- Command-to-counter and command-to-flag latency is 1 cycle: the flags are valid on the cycle after the accepting edge.
- rd_value has 1 cycle latency and reflects the counter after any same-edge update on that channel. It is a write-through read: rd_value equals the new value when rd_ch == cmd_ch in the same cycle.
- There is no backpressure. Back-to-back commands to the same channel accumulate, e.g. INC, INC, DEC nets +1 after 3 cycles.
- If reset_n is low in the same cycle as a valid command, reset wins and the command is lost.

## Configuration
- TEMP_TRACKER_SAT_EN defined: INC at max holds max and DEC at min holds min; ovf still sets.
- TEMP_TRACKER_SAT_EN undefined: two's-complement wrap. For example, WIDTH=8 gives 127 + 1 → -128 and -128 - 1 → 127. ovf sets on the wrap.
- The macro has no effect on the port list, flags or latency.

## Test plan
- Reset, then idle: counters 0, zero=4'b1111, negative=positive=alarm=ovf=0, rd_value=0.
- LOAD ch2=-3, then INC×4 on ch2:
  - after LOAD: negative[2]=1;
  - after 3rd INC: zero[2]=1;
  - after 4th INC: positive[2]=1 and rd_value(rd_ch=2)=1;
  - ch0, ch1 and ch3 are unchanged throughout.
- Hysteresis on ch1:
  - LOAD 29 → alarm[1]=0; INC → 30, alarm[1]=1;
  - DEC×4 → 26, alarm stays 1; DEC → 25, alarm[1]=0.
- Boundary on ch0: LOAD 127, then INC.
  - With TEMP_TRACKER_SAT_EN: counter 127, ovf[0]=1.
  - Without it: counter -128, negative[0]=1, ovf[0]=1.
  - Then LOAD 0: ovf[0]=0.
- Drop and priority checks:
  - cmd_ch=3 with CHANNELS=3 → no change;
  - cmd_valid=0 with op=LOAD → no change;
  - reset_n=0 with a LOAD of 5 → counter 0.
- Write-through read: rd_ch=cmd_ch=1 while LOAD 7 → rd_value=7 on the next cycle.
